operand_issue_stage: RTL and testbench

OPERAND_ISSUE_STAGE -- requirements
Module: operand_issue_stage

---
 rtl/operand_issue_stage.sv | 76 +++++++
 tb/tb_operand_issue_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue_stage.sv
// operand_issue_stage: 4x4-bit register file that decodes LDI/ADD/NOP/CLR and
// hands ADD operand pairs to an external adder, writing its result back.
module operand_issue_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [3:0]       out_a,
  output logic [3:0]       out_b,
  input  logic             out_ready,
  input  logic             res_valid,
  input  logic [3:0]       res_data,
  input  logic [1:0]       dbg_sel,
  output logic [3:0]       dbg_data,
  output logic [CNT_W-1:0] issue_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_t;
  state_t           state_q;
  logic [3:0]       rf_q [4];
  logic [3:0]       a_q, b_q;
  logic [1:0]       tag_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op, rd, rs1, rs2;
  logic [3:0]       imm;
  assign op  = in_data[7:6];
  assign rd  = in_data[5:4];
  assign rs1 = in_data[3:2];
  assign rs2 = in_data[1:0];
  assign imm = in_data[3:0];
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == ISSUE;
  assign out_a     = out_valid ? a_q : 4'd0;
  assign out_b     = out_valid ? b_q : 4'd0;
  assign dbg_data  = rf_q[dbg_sel];
  assign issue_cnt = cnt_q;
  // Operands are captured at accept so write-back to rd cannot disturb them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rf_q    <= '{default: '0};
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          case (op)
            2'b00: rf_q[rd] <= imm;
            2'b01: begin
              a_q     <= rf_q[rs1];
              b_q     <= rf_q[rs2];
              tag_q   <= rd;
              state_q <= ISSUE;
            end
            2'b11: rf_q <= '{default: '0};
            default: ;
          endcase
        end
        ISSUE: if (out_ready) begin
          state_q <= WAIT_RES;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        WAIT_RES: if (res_valid) begin
          rf_q[tag_q] <= res_data;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_issue_stage.sv
// tb_operand_issue_stage: directed scenarios plus a randomized instruction
// stream checked against a transaction-level register/counter model.
module tb_operand_issue_stage;
  logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, res_valid = 0;
  logic [7:0] in_data = 0;
  logic [3:0] res_data = 0;
  logic [1:0] dbg_sel = 0;
  logic       in_ready, out_valid;
  logic [3:0] out_a, out_b, dbg_data;
  logic [7:0] issue_cnt;
  int         n_chk = 0, n_fail = 0, exp_n = 0;
  logic [3:0] mr [4] = '{default: '0};

  operand_issue_stage #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
    .out_ready(out_ready), .res_valid(res_valid), .res_data(res_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ins);
    in_valid = 1;
    in_data  = ins;
    tick;
    in_valid = 0;
  endtask

  task automatic add_trip(input logic [1:0] rd, rs1, rs2, input logic [3:0] res);
    send({2'b01, rd, rs1, rs2});
    out_ready = 1;
    tick;
    out_ready = 0;
    res_valid = 1;
    res_data  = res;
    tick;
    res_valid = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; in_valid = 1; in_data = 8'h0F; out_ready = 1; res_valid = 1; res_data = 4'hF;
    tick; tick;
    rst_n = 1; in_valid = 0; out_ready = 0; res_valid = 0;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_chk++; if ({out_a, out_b} !== 8'h00) begin n_fail++; $display("FAIL reset operands: got %h want 00", {out_a, out_b}); end
    n_chk++; if (issue_cnt !== 8'd0) begin n_fail++; $display("FAIL reset issue_cnt: got %0d want 0", issue_cnt); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_chk++; if (dbg_data !== 4'h0) begin n_fail++; $display("FAIL reset R%0d: got %h want 0", i, dbg_data); end
    end
  endtask

  task automatic test_basic_add;
    send(8'h15); mr[1] = 4'h5;
    send(8'h23); mr[2] = 4'h3;
    out_ready = 1;
    send({2'b01, 2'd3, 2'd1, 2'd2});
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic out_valid: got %b want 1", out_valid); end
    n_chk++; if ({out_a, out_b} !== 8'h53) begin n_fail++; $display("FAIL basic operands: got %h want 53", {out_a, out_b}); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic in_ready: got %b want 0", in_ready); end
    tick; out_ready = 0; exp_n++;
    n_chk++; if (issue_cnt !== 8'(exp_n)) begin n_fail++; $display("FAIL basic issue_cnt: got %0d want %0d", issue_cnt, exp_n); end
    n_chk++; if ({out_valid, out_a, out_b} !== 9'h0) begin n_fail++; $display("FAIL basic idle operands: got %h want 0", {out_valid, out_a, out_b}); end
    res_valid = 1; res_data = 4'h8; tick; res_valid = 0; mr[3] = 4'h8;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic return in_ready: got %b want 1", in_ready); end
    dbg_sel = 2'd3; #1;
    n_chk++; if (dbg_data !== 4'h8) begin n_fail++; $display("FAIL basic R3: got %h want 8", dbg_data); end
  endtask

  task automatic test_stall;
    send({2'b01, 2'd0, 2'd1, 2'd2});
    for (int c = 0; c < 4; c++) begin
      in_valid = 1; in_data = 8'h1A; tick;
      n_chk++; if ({out_valid, in_ready, out_a, out_b} !== 10'b10_0101_0011) begin
        n_fail++; $display("FAIL stall c%0d: got v=%b r=%b a=%h b=%h want v=1 r=0 a=5 b=3", c, out_valid, in_ready, out_a, out_b);
      end
    end
    in_valid = 0; out_ready = 1; tick; out_ready = 0; exp_n++;
    res_valid = 1; res_data = 4'h7; tick; res_valid = 0; mr[0] = 4'h7;
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_chk++; if (dbg_data !== mr[i]) begin n_fail++; $display("FAIL stall R%0d: got %h want %h", i, dbg_data, mr[i]); end
    end
  endtask

  task automatic test_res_ignore;
    res_valid = 1; res_data = 4'hF; out_ready = 1; tick; tick;
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_chk++; if (dbg_data !== mr[i]) begin n_fail++; $display("FAIL idle_res R%0d: got %h want %h", i, dbg_data, mr[i]); end
    end
    n_chk++; if (issue_cnt !== 8'(exp_n)) begin n_fail++; $display("FAIL idle_ready issue_cnt: got %0d want %0d", issue_cnt, exp_n); end
    send({2'b01, 2'd2, 2'd1, 2'd1});
    out_ready = 1; tick; out_ready = 0; exp_n++;
    n_chk++; if ({out_valid, in_ready} !== 2'b00) begin n_fail++; $display("FAIL handshake_res state: got v=%b r=%b want 0 0", out_valid, in_ready); end
    res_data = 4'h6; tick; res_valid = 0; mr[2] = 4'h6;
    dbg_sel = 2'd2; #1;
    n_chk++; if (dbg_data !== 4'h6) begin n_fail++; $display("FAIL handshake_res R2: got %h want 6", dbg_data); end
  endtask

  task automatic test_rbw;
    send(8'h0F); mr[0] = 4'hF;
    send({2'b01, 2'd0, 2'd0, 2'd0});
    n_chk++; if ({out_a, out_b} !== 8'hFF) begin n_fail++; $display("FAIL rbw operands: got %h want FF", {out_a, out_b}); end
    out_ready = 1; tick; out_ready = 0; exp_n++;
    res_valid = 1; res_data = 4'hE; tick; res_valid = 0; mr[0] = 4'hE;
    dbg_sel = 2'd0; #1;
    n_chk++; if (dbg_data !== 4'hE) begin n_fail++; $display("FAIL rbw R0: got %h want E", dbg_data); end
  endtask

  task automatic test_reset_mid;
    send({2'b01, 2'd3, 2'd1, 2'd2});
    out_ready = 1; tick; out_ready = 0;
    rst_n = 0; res_valid = 1; res_data = 4'h9; tick;
    rst_n = 1; tick; res_valid = 0;
    exp_n = 0; mr = '{default: '0};
    n_chk++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL reset_mid state: got r=%b v=%b want 1 0", in_ready, out_valid); end
    n_chk++; if (issue_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_mid issue_cnt: got %0d want 0", issue_cnt); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_chk++; if (dbg_data !== 4'h0) begin n_fail++; $display("FAIL reset_mid R%0d: got %h want 0", i, dbg_data); end
    end
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 257; k++) begin
      add_trip(2'(k), 2'(k + 1), 2'(k + 2), 4'(k | 1));
      exp_n++;
      if (k == 254 || k == 255) begin
        n_chk++; if (issue_cnt !== 8'(exp_n % 256)) begin n_fail++; $display("FAIL wrap k%0d: got %0d want %0d", k, issue_cnt, exp_n % 256); end
      end
    end
    n_chk++; if (issue_cnt !== 8'd1) begin n_fail++; $display("FAIL wrap final issue_cnt: got %0d want 1", issue_cnt); end
    send(8'hC0); mr = '{default: '0};
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_chk++; if (dbg_data !== 4'h0) begin n_fail++; $display("FAIL clr R%0d: got %h want 0", i, dbg_data); end
    end
  endtask

  task automatic test_random;
    logic [7:0] ins;
    logic [3:0] ea, eb, rv;
    logic [1:0] sel;
    for (int it = 0; it < 200; it++) begin
      ins = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        res_valid = 1; res_data = 4'($urandom); out_ready = 1'($urandom); tick;
        res_valid = 0; out_ready = 0;
      end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rand it%0d in_ready: got %b want 1", it, in_ready); end
      ea = mr[ins[3:2]]; eb = mr[ins[1:0]];
      send(ins);
      case (ins[7:6])
        2'b00: mr[ins[5:4]] = ins[3:0];
        2'b11: mr = '{default: '0};
        2'b01: begin
          for (int s = $urandom_range(0, 3); s >= 0; s--) begin
            n_chk++; if ({out_valid, out_a, out_b} !== {1'b1, ea, eb}) begin
              n_fail++; $display("FAIL rand it%0d issue: got v=%b a=%h b=%h want v=1 a=%h b=%h", it, out_valid, out_a, out_b, ea, eb);
            end
            if (s > 0) tick;
          end
          out_ready = 1; tick; out_ready = 0; exp_n++;
          n_chk++; if (issue_cnt !== 8'(exp_n % 256)) begin n_fail++; $display("FAIL rand it%0d issue_cnt: got %0d want %0d", it, issue_cnt, exp_n % 256); end
          repeat ($urandom_range(0, 2)) tick;
          n_chk++; if ({out_valid, in_ready, out_a, out_b} !== 10'd0) begin n_fail++; $display("FAIL rand it%0d wait: got v=%b r=%b", it, out_valid, in_ready); end
          rv = 4'($urandom);
          res_valid = 1; res_data = rv; tick; res_valid = 0;
          mr[ins[5:4]] = rv;
        end
        default: ;
      endcase
      sel = 2'($urandom); dbg_sel = sel; #1;
      n_chk++; if (dbg_data !== mr[sel]) begin n_fail++; $display("FAIL rand it%0d R%0d: got %h want %h", it, sel, dbg_data, mr[sel]); end
    end
  endtask

  initial begin
    test_reset;
    test_basic_add;
    test_stall;
    test_res_ignore;
    test_rbw;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
